// File: rtl/kb_pkg.sv
// Shared encodings for the PS/2 keyboard host controller: FSM states,
// PS/2 command/response bytes and the lock-key scan codes.
package kb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_CMD,
    ST_WAIT_CMD_DONE,
    ST_WAIT_CMD_ACK,
    ST_TX_ARG,
    ST_WAIT_ARG_DONE,
    ST_WAIT_ARG_ACK
  } kbState_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] SC_BREAK     = 8'hF0;
  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_CAPS      = 8'h58;
  localparam logic [7:0] SC_NUM       = 8'h77;
  localparam logic [7:0] SC_SCROLL    = 8'h7E;

  // Bit positions follow the argument layout of the 0xED command.
  function automatic logic [2:0] ledMask(input logic [7:0] code);
    case (code)
      SC_CAPS:   return 3'b100;
      SC_NUM:    return 3'b010;
      SC_SCROLL: return 3'b001;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic isWait(input kbState_e st);
    return (st == ST_WAIT_CMD_DONE) || (st == ST_WAIT_CMD_ACK) ||
           (st == ST_WAIT_ARG_DONE) || (st == ST_WAIT_ARG_ACK);
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// First-word fall-through scan-code buffer; a push while full succeeds only
// when a pop frees a slot in the same cycle, otherwise the byte is dropped.
module kb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] popData_o,
  output logic             valid_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             empty;
  logic             full;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty  = (wrPtr_q == rdPtr_q);
  assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                  (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPop  = pop_i && !empty;
  assign doPush = push_i && (!full || doPop);
  assign drop_o = push_i && full && !doPop;

  assign popData_o = mem_q[rdPtr_q[AW-1:0]];
  assign valid_o   = !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

endmodule

// File: rtl/kb_host_ctrl.sv
// PS/2 keyboard host: tracks lock keys from the scan stream, mirrors them to
// the keyboard LEDs via 0xED with ACK/resend handling, and buffers scan codes.
module kb_host_ctrl
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 2_000_000,
  parameter int MAX_RETRIES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_rx_data,
  input  logic       ps2_rx_done_tick,
  input  logic       ps2_tx_done_tick,
  output logic [7:0] ps2_tx_data,
  output logic       ps2_write,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_valid,
  input  logic       uart_tx_ready,
  output logic [2:0] led_state,
  output logic       fifo_overflow,
  output logic       cmd_error
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);

  kbState_e    state_q, state_d;
  logic [2:0]  ledState_q, ledState_d;
  logic [2:0]  snap_q, snap_d;
  logic        updatePend_q, updatePend_d;
  logic        breakPend_q, breakPend_d;
  logic        extPend_q, extPend_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]  txData_q, txData_d;
  logic        write_q, write_d;
  logic        overflow_q;
  logic        waitAck;
  logic        rxConsumed;
  logic        rxKeep;
  logic        fifoDrop;
  logic [2:0]  toggleMask;
  logic        timeoutHit;

  // ACK/resend bytes are swallowed only while the FSM is expecting a reply.
  assign waitAck    = (state_q == ST_WAIT_CMD_ACK) || (state_q == ST_WAIT_ARG_ACK);
  assign rxConsumed = ps2_rx_done_tick && waitAck &&
                      ((ps2_rx_data == RSP_ACK) || (ps2_rx_data == RSP_RESEND));
  assign rxKeep     = ps2_rx_done_tick && !rxConsumed;
  assign timeoutHit = (timer_q == TW'(1));

  always_comb begin
    breakPend_d  = breakPend_q;
    extPend_d    = extPend_q;
    toggleMask   = 3'b000;
    if (rxKeep) begin
      if (ps2_rx_data == SC_BREAK) begin
        breakPend_d = 1'b1;
      end else if (ps2_rx_data == SC_EXT) begin
        extPend_d = 1'b1;
      end else begin
        if (!breakPend_q && !extPend_q) toggleMask = ledMask(ps2_rx_data);
        breakPend_d = 1'b0;
        extPend_d   = 1'b0;
      end
    end
    ledState_d   = ledState_q ^ toggleMask;
    updatePend_d = updatePend_q;
    if (state_q == ST_TX_CMD) updatePend_d = 1'b0;
    if (|toggleMask) updatePend_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    txData_d  = txData_q;
    snap_d    = snap_q;
    write_d   = 1'b0;
    cmd_error = 1'b0;
    if (isWait(state_q)) timer_d = timer_q - TW'(1);
    case (state_q)
      ST_IDLE: begin
        if (updatePend_q) begin
          state_d = ST_TX_CMD;
          retry_d = '0;
        end
      end
      ST_TX_CMD: begin
        txData_d = CMD_SET_LEDS;
        write_d  = 1'b1;
        timer_d  = TW'(ACK_TIMEOUT);
        state_d  = ST_WAIT_CMD_DONE;
      end
      ST_WAIT_CMD_DONE: begin
        if (ps2_tx_done_tick) begin
          timer_d = TW'(ACK_TIMEOUT);
          state_d = ST_WAIT_CMD_ACK;
        end else if (timeoutHit) begin
          cmd_error = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_CMD_ACK: begin
        if (rxConsumed && ps2_rx_data == RSP_ACK) begin
          retry_d = '0;
          snap_d  = ledState_q;
          state_d = ST_TX_ARG;
        end else if (rxConsumed) begin
          if (retry_q == RW'(MAX_RETRIES)) begin
            cmd_error = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = ST_TX_CMD;
          end
        end else if (timeoutHit) begin
          cmd_error = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_TX_ARG: begin
        txData_d = {5'b00000, snap_q};
        write_d  = 1'b1;
        timer_d  = TW'(ACK_TIMEOUT);
        state_d  = ST_WAIT_ARG_DONE;
      end
      ST_WAIT_ARG_DONE: begin
        if (ps2_tx_done_tick) begin
          timer_d = TW'(ACK_TIMEOUT);
          state_d = ST_WAIT_ARG_ACK;
        end else if (timeoutHit) begin
          cmd_error = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_ARG_ACK: begin
        if (rxConsumed && ps2_rx_data == RSP_ACK) begin
          retry_d = '0;
          state_d = ST_IDLE;
        end else if (rxConsumed) begin
          if (retry_q == RW'(MAX_RETRIES)) begin
            cmd_error = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = ST_TX_ARG;
          end
        end else if (timeoutHit) begin
          cmd_error = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ledState_q   <= '0;
      snap_q       <= '0;
      updatePend_q <= 1'b0;
      breakPend_q  <= 1'b0;
      extPend_q    <= 1'b0;
      retry_q      <= '0;
      timer_q      <= '0;
      txData_q     <= '0;
      write_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ledState_q   <= ledState_d;
      snap_q       <= snap_d;
      updatePend_q <= updatePend_d;
      breakPend_q  <= breakPend_d;
      extPend_q    <= extPend_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      txData_q     <= txData_d;
      write_q      <= write_d;
      overflow_q   <= overflow_q | fifoDrop;
    end
  end

  kb_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (rxKeep),
    .pushData_i(ps2_rx_data),
    .pop_i     (uart_tx_ready),
    .popData_o (uart_tx_data),
    .valid_o   (uart_tx_valid),
    .drop_o    (fifoDrop)
  );

  assign ps2_tx_data   = txData_q;
  assign ps2_write     = write_q;
  assign led_state     = ledState_q;
  assign fifo_overflow = overflow_q;

endmodule

// File: tb/tb_kb_host_ctrl.sv
// Directed bench for kb_host_ctrl: LED update handshakes, retries, timeout,
// prefix decoding, FIFO full/overflow behaviour and mid-sequence reset.
module tb_kb_host_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_rx_data = 8'h00;
  logic       ps2_rx_done_tick = 1'b0;
  logic       ps2_tx_done_tick = 1'b0;
  logic [7:0] ps2_tx_data;
  logic       ps2_write;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid;
  logic       uart_tx_ready = 1'b0;
  logic [2:0] led_state;
  logic       fifo_overflow;
  logic       cmd_error;

  int nChecks = 0;
  int nFail = 0;
  int writeCount = 0;
  int errCount = 0;
  int cycleCnt = 0;
  int errCycle = 0;
  int doneCycle = 0;
  logic [7:0] lastTx = 8'h00;

  kb_host_ctrl #(
    .FIFO_DEPTH (4),
    .ACK_TIMEOUT(100),
    .MAX_RETRIES(3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ps2_rx_data     (ps2_rx_data),
    .ps2_rx_done_tick(ps2_rx_done_tick),
    .ps2_tx_done_tick(ps2_tx_done_tick),
    .ps2_tx_data     (ps2_tx_data),
    .ps2_write       (ps2_write),
    .uart_tx_data    (uart_tx_data),
    .uart_tx_valid   (uart_tx_valid),
    .uart_tx_ready   (uart_tx_ready),
    .led_state       (led_state),
    .fifo_overflow   (fifo_overflow),
    .cmd_error       (cmd_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Pulses are observed mid-cycle, well clear of the rising edge.
  always @(negedge clk) begin
    if (ps2_write) begin
      writeCount++;
      lastTx = ps2_tx_data;
    end
    if (cmd_error) begin
      errCount++;
      errCycle = cycleCnt;
    end
    if (ps2_tx_done_tick) doneCycle = cycleCnt;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rxByte(input logic [7:0] b);
    ps2_rx_data      = b;
    ps2_rx_done_tick = 1'b1;
    tick();
    ps2_rx_done_tick = 1'b0;
  endtask

  task automatic txDone();
    ps2_tx_done_tick = 1'b1;
    tick();
    ps2_tx_done_tick = 1'b0;
  endtask

  task automatic waitWrites(input int n, input string tag);
    for (int i = 0; i < 40 && writeCount < n; i++) tick();
    checkOutput(tag, writeCount, n);
  endtask

  task automatic popExpect(input logic [7:0] exp, input string tag);
    checkOutput({tag, " valid"}, uart_tx_valid, 1);
    checkOutput({tag, " data"}, uart_tx_data, exp);
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
  endtask

  task automatic applyStimulus();
    #2 reset = 1'b0;
    tick();
    tick();
    checkOutput("reset led", led_state, 3'b000);
    checkOutput("reset write", ps2_write, 0);
    checkOutput("reset txdata", ps2_tx_data, 8'h00);
    checkOutput("reset valid", uart_tx_valid, 0);
    checkOutput("reset ovf", fifo_overflow, 0);
    checkOutput("reset err", cmd_error, 0);
    reset = 1'b1;
    tick();

    // Caps update, then num toggled while the argument ACK is pending.
    rxByte(8'h58);
    checkOutput("caps led", led_state, 3'b100);
    checkOutput("caps pushed valid", uart_tx_valid, 1);
    checkOutput("caps pushed data", uart_tx_data, 8'h58);
    waitWrites(1, "cmd write 1");
    checkOutput("cmd byte 1", lastTx, 8'hED);
    txDone();
    rxByte(8'hFA);
    waitWrites(2, "arg write 1");
    checkOutput("arg byte 1", lastTx, 8'h04);
    txDone();
    rxByte(8'h77);
    checkOutput("num led", led_state, 3'b110);
    rxByte(8'hFA);
    waitWrites(3, "cmd write 2");
    checkOutput("cmd byte 2", lastTx, 8'hED);
    txDone();
    rxByte(8'hFA);
    waitWrites(4, "arg write 2");
    checkOutput("arg byte 2", lastTx, 8'h06);
    txDone();
    rxByte(8'hFA);
    repeat (10) tick();
    checkOutput("no extra writes", writeCount, 4);
    checkOutput("no error", errCount, 0);
    popExpect(8'h58, "fifo caps");
    popExpect(8'h77, "fifo num");
    checkOutput("fifo empty 1", uart_tx_valid, 0);

    // Break and extended prefixes suppress toggles.
    rxByte(8'hF0);
    rxByte(8'h58);
    rxByte(8'hE0);
    rxByte(8'h77);
    repeat (10) tick();
    checkOutput("prefix no write", writeCount, 4);
    checkOutput("prefix led", led_state, 3'b110);
    checkOutput("prefix full no ovf", fifo_overflow, 0);
    popExpect(8'hF0, "fifo f0");
    popExpect(8'h58, "fifo brk58");
    popExpect(8'hE0, "fifo e0");
    popExpect(8'h77, "fifo ext77");

    // Resend exhausts the retry budget.
    rxByte(8'h7E);
    checkOutput("scroll led", led_state, 3'b111);
    for (int k = 0; k < 4; k++) begin
      waitWrites(5 + k, "retry write");
      checkOutput("retry byte", lastTx, 8'hED);
      txDone();
      rxByte(8'hFE);
    end
    repeat (10) tick();
    checkOutput("retry err count", errCount, 1);
    checkOutput("retry write total", writeCount, 8);
    checkOutput("retry led kept", led_state, 3'b111);
    popExpect(8'h7E, "fifo scroll");
    checkOutput("fifo empty 2", uart_tx_valid, 0);

    // Silent keyboard after the command byte.
    rxByte(8'h77);
    checkOutput("num2 led", led_state, 3'b101);
    waitWrites(9, "timeout cmd write");
    txDone();
    for (int i = 0; i < 200 && errCount < 2; i++) tick();
    checkOutput("timeout err", errCount, 2);
    checkOutput("timeout latency", errCycle - doneCycle, 100);
    checkOutput("timeout writes", writeCount, 9);
    rxByte(8'h77);
    checkOutput("num3 led", led_state, 3'b111);
    waitWrites(10, "restart cmd write");
    checkOutput("restart cmd byte", lastTx, 8'hED);
    txDone();
    rxByte(8'hFA);
    waitWrites(11, "restart arg write");
    checkOutput("restart arg byte", lastTx, 8'h07);
    txDone();
    rxByte(8'hFA);
    popExpect(8'h77, "fifo num2");
    popExpect(8'h77, "fifo num3");

    // Overflow with a stalled consumer.
    checkOutput("fifo empty 3", uart_tx_valid, 0);
    rxByte(8'h11);
    rxByte(8'h22);
    rxByte(8'h33);
    rxByte(8'h44);
    checkOutput("ovf at full", fifo_overflow, 0);
    rxByte(8'h55);
    checkOutput("ovf set", fifo_overflow, 1);
    rxByte(8'h66);
    popExpect(8'h11, "ovf d0");
    popExpect(8'h22, "ovf d1");
    popExpect(8'h33, "ovf d2");
    popExpect(8'h44, "ovf d3");
    checkOutput("ovf drained", uart_tx_valid, 0);
    checkOutput("ovf sticky", fifo_overflow, 1);

    // Simultaneous push and pop while full.
    rxByte(8'hA1);
    rxByte(8'hA2);
    rxByte(8'hA3);
    rxByte(8'hA4);
    uart_tx_ready    = 1'b1;
    ps2_rx_data      = 8'hB5;
    ps2_rx_done_tick = 1'b1;
    tick();
    uart_tx_ready    = 1'b0;
    ps2_rx_done_tick = 1'b0;
    popExpect(8'hA2, "pp d0");
    popExpect(8'hA3, "pp d1");
    popExpect(8'hA4, "pp d2");
    popExpect(8'hB5, "pp d3");
    checkOutput("pp drained", uart_tx_valid, 0);

    // Reset in the middle of an update sequence.
    rxByte(8'h58);
    checkOutput("pre-reset led", led_state, 3'b011);
    waitWrites(12, "pre-reset cmd write");
    reset = 1'b0;
    tick();
    tick();
    checkOutput("mid reset led", led_state, 3'b000);
    checkOutput("mid reset valid", uart_tx_valid, 0);
    checkOutput("mid reset txdata", ps2_tx_data, 8'h00);
    checkOutput("mid reset ovf", fifo_overflow, 0);
    reset = 1'b1;
    repeat (20) tick();
    checkOutput("post reset writes", writeCount, 12);
    checkOutput("post reset errs", errCount, 2);
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/kb_host_ctrl.md
KB_HOST_CTRL -- requirements
Module: kb_host_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, scan-code buffer depth; SHALL be a power of 2, minimum 2.
REQ-002 Parameter ACK_TIMEOUT, default 2_000_000, clk cycles to wait for each keyboard response byte.
REQ-003 Parameter MAX_RETRIES, default 3, resends allowed per command byte after 0xFE.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 ps2_rx_data  in  8  byte from ps2_transceiver.
REQ-007 ps2_rx_done_tick  in  1  one-cycle pulse; ps2_rx_data valid.
REQ-008 ps2_tx_done_tick  in  1  one-cycle pulse; host-to-device byte finished.
REQ-009 ps2_tx_data  out  8  byte to send; registered and stable from ps2_write until ps2_tx_done_tick.
REQ-010 ps2_write  out  1  one-cycle pulse starting a transmit.
REQ-011 uart_tx_data  out  8  FIFO head byte.
REQ-012 uart_tx_valid  out  1  FIFO non-empty.
REQ-013 uart_tx_ready  in  1  consumer accepts; pop on valid and ready in the same cycle.
REQ-014 led_state  out  3  lock flags: bit2 caps, bit1 num, bit0 scroll; PS/2 0xED argument layout.
REQ-015 fifo_overflow  out  1  sticky; set on a dropped byte.
REQ-016 cmd_error  out  1  one-cycle pulse on LED-update abort.

Function
REQ-017 Decoder SHALL track prefixes: 0xF0 sets break_pend; 0xE0 sets ext_pend; both clear on the next non-prefix byte.
REQ-018 Non-prefix byte with break_pend=0 and ext_pend=0 SHALL toggle led_state: 0x58 bit2, 0x77 bit1, 0x7E bit0; led_state changes the cycle after the rx tick.
REQ-019 A toggle SHALL set update_pend; multiple toggles before service SHALL coalesce into one update.
REQ-020 Every received byte SHALL be pushed to the FIFO, except 0xFA/0xFE consumed while waiting for an ACK.
REQ-021 FSM states: IDLE, TX_CMD, WAIT_CMD_DONE, WAIT_CMD_ACK, TX_ARG, WAIT_ARG_DONE, WAIT_ARG_ACK.
REQ-022 IDLE with update_pend=1 -> TX_CMD; TX_CMD drives 0xED, pulses ps2_write, clears update_pend -> WAIT_CMD_DONE.
REQ-023 WAIT_x_DONE -> WAIT_x_ACK on ps2_tx_done_tick; timeout counter loads ACK_TIMEOUT on entry to each WAIT state.
REQ-024 WAIT_CMD_ACK: 0xFA -> TX_ARG; 0xFE -> TX_CMD, retry+1; TX_ARG sends the led_state snapshot taken on its entry.
REQ-025 WAIT_ARG_ACK: 0xFA -> IDLE; 0xFE -> TX_ARG with the same snapshot, retry+1.
REQ-026 Retry counter SHALL clear on each 0xFA and on leaving IDLE.
REQ-027 0xFE when retry = MAX_RETRIES, or timeout expiry in any WAIT state, SHALL pulse cmd_error and go to IDLE; led_state is retained.
REQ-028 A toggle during an active sequence SHALL leave update_pend=1, so the FSM restarts from TX_CMD after returning to IDLE.
REQ-029 FIFO: first-word fall-through; push while full and no pop SHALL drop the byte and set fifo_overflow.
REQ-030 Push and pop in the same cycle SHALL both succeed when full; a push while empty appears on uart_tx_valid the next cycle.

Reset
REQ-031 On reset low: state=IDLE, led_state=0, update_pend, break_pend and ext_pend=0, FIFO empty, pointers 0.
REQ-032 On reset low: ps2_write=0, ps2_tx_data=0, uart_tx_valid=0, fifo_overflow=0, cmd_error=0, counters 0.
REQ-033 Reset asserted mid-sequence SHALL abort immediately with no further ps2_write.

Structure
REQ-034 Package kb_pkg SHALL hold the FSM state encoding and constants 0xED, 0xFA, 0xFE, 0xF0, 0xE0, 0x58, 0x77, 0x7E.
REQ-035 Scan-code buffer SHALL be sub-module kb_fifo, parametrised on width and depth; ps2_transceiver stays outside this block.

Verification
REQ-036 Rx 0x58; reply 0xFA after each tx_done -> writes 0xED then 0x04, led_state=3'b100, FIFO holds 0x58.
REQ-037 Rx 0xF0,0x58 -> no ps2_write, led_state unchanged, FIFO holds 0xF0,0x58.
REQ-038 After 0xED, reply 0xFE four times with MAX_RETRIES=3 -> exactly four 0xED writes, then a cmd_error pulse and IDLE.
REQ-039 No reply after 0xED, ACK_TIMEOUT=100 -> cmd_error 100 cycles after tx_done; a new 0x77 restarts a sequence.
REQ-040 FIFO_DEPTH=4, uart_tx_ready=0, rx 6 bytes -> first 4 retained in order, fifo_overflow=1; then ready=1 drains 4 bytes.
REQ-041 Rx 0x77 during WAIT_ARG_ACK of a caps update -> second 0xED sequence sends 0x06.
